// File: rtl/rotor_stepper.sv
// Enigma rotor position/stepping stage: advances the three rotors per key and emits
// (key + right position) mod 26 through a one-entry valid/ready buffer. Optional: ENIGMA_DOUBLE_STEP_EN.
module rotor_stepper (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [4:0] init_l,
    input  logic [4:0] init_m,
    input  logic [4:0] init_r,
    input  logic [2:0] type_l,
    input  logic [2:0] type_m,
    input  logic [2:0] type_r,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [4:0] key_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_code,
    output logic [4:0] pos_l,
    output logic [4:0] pos_m,
    output logic [4:0] pos_r
);

    // Types VI..VIII carry two notches (Z and M); the rest have one.
    function automatic logic at_notch(input logic [2:0] rtype, input logic [4:0] pos);
        case (rtype)
            3'd0:    at_notch = (pos == 5'd16);
            3'd1:    at_notch = (pos == 5'd4);
            3'd2:    at_notch = (pos == 5'd21);
            3'd3:    at_notch = (pos == 5'd9);
            3'd4:    at_notch = (pos == 5'd25);
            default: at_notch = (pos == 5'd25) || (pos == 5'd12);
        endcase
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] p);
        return (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    logic       r_notch, m_notch;
    logic       step_m, step_l;
    logic [4:0] next_l, next_m, next_r;
    logic [5:0] sum, wrapped;
    logic [4:0] code_next;
    logic       accept, key_ok;

    assign key_ready = !load && (!out_valid || out_ready);
    assign accept    = key_valid && key_ready;
    assign key_ok    = (key_code < 5'd26);

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        r_notch = at_notch(type_r, pos_r);
        m_notch = at_notch(type_m, pos_m);
`ifdef ENIGMA_DOUBLE_STEP_EN
        step_m  = r_notch || m_notch;
        step_l  = m_notch;
`else
        step_m  = r_notch;
        step_l  = r_notch && m_notch;
`endif
        next_r    = inc26(pos_r);
        next_m    = step_m ? inc26(pos_m) : pos_m;
        next_l    = step_l ? inc26(pos_l) : pos_l;
        sum       = {1'b0, key_code} + {1'b0, next_r};
        wrapped   = (sum >= 6'd26) ? (sum - 6'd26) : sum;
        code_next = wrapped[4:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_l     <= 5'd0;
            pos_m     <= 5'd0;
            pos_r     <= 5'd0;
            out_valid <= 1'b0;
            out_code  <= 5'd0;
        end else if (load) begin
            pos_l     <= init_l;
            pos_m     <= init_m;
            pos_r     <= init_r;
            out_valid <= 1'b0;
        end else if (accept && key_ok) begin
            pos_l     <= next_l;
            pos_m     <= next_m;
            pos_r     <= next_r;
            out_valid <= 1'b1;
            out_code  <= code_next;
        end else if (out_ready) begin
            // An out-of-range key is consumed here too: it only ever drains the buffer.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rotor_stepper.sv
// Self-checking bench for rotor_stepper: directed cases plus random traffic against
// a plain-arithmetic model of the rotor rules. Honours ENIGMA_DOUBLE_STEP_EN.
module tb_rotor_stepper;

    logic       clk = 1'b0;
    logic       rst_n, load, key_valid, out_ready;
    logic [4:0] init_l, init_m, init_r, key_code;
    logic [2:0] type_l, type_m, type_r;
    logic       key_ready, out_valid;
    logic [4:0] out_code, pos_l, pos_m, pos_r;

    int n_pass   = 0;
    int n_checks = 0;

    int m_l, m_m, m_r, m_code;
    bit m_valid;
    int t_l, t_m, t_r;
    int notch_a[8] = '{16, 4, 21, 9, 25, 25, 25, 25};
    int notch_b[8] = '{-1, -1, -1, -1, -1, 12, 12, 12};

    always #5 clk = ~clk;

    rotor_stepper dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .init_l(init_l), .init_m(init_m), .init_r(init_r),
        .type_l(type_l), .type_m(type_m), .type_r(type_r),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic bit notched(input int t, input int p);
        return (p == notch_a[t]) || (p == notch_b[t]);
    endfunction

    task automatic model_key(input int kc);
        bit rn, mn;
        rn  = notched(t_r, m_r);
        mn  = notched(t_m, m_m);
        m_r = (m_r + 1) % 26;
`ifdef ENIGMA_DOUBLE_STEP_EN
        if (rn || mn) m_m = (m_m + 1) % 26;
        if (mn)       m_l = (m_l + 1) % 26;
`else
        if (rn)       m_m = (m_m + 1) % 26;
        if (rn && mn) m_l = (m_l + 1) % 26;
`endif
        m_code  = (kc + m_r) % 26;
        m_valid = 1'b1;
    endtask

    task automatic compare_all();
        check("pos_l", pos_l, m_l);
        check("pos_m", pos_m, m_m);
        check("pos_r", pos_r, m_r);
        check("out_valid", out_valid, m_valid);
        if (m_valid) check("out_code", out_code, m_code);
    endtask

    // One clock: drive inputs, check key_ready, update model, cross the edge, compare.
    task automatic cycle(input bit ld, input int il, input int im, input int ir,
                         input bit kv, input int kc, input bit ordy);
        bit exp_kr;
        load      = ld;
        init_l    = 5'(il);
        init_m    = 5'(im);
        init_r    = 5'(ir);
        type_l    = 3'(t_l);
        type_m    = 3'(t_m);
        type_r    = 3'(t_r);
        key_valid = kv;
        key_code  = 5'(kc);
        out_ready = ordy;
        #1;
        exp_kr = !ld && (!m_valid || ordy);
        check("key_ready", key_ready, exp_kr);
        if (ld) begin
            m_l = il; m_m = im; m_r = ir; m_valid = 1'b0;
        end else if (exp_kr && kv) begin
            if (kc < 26) model_key(kc);
            else m_valid = 1'b0;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic load_pos(input int l, input int m, input int r);
        cycle(1'b1, l, m, r, 1'b0, 0, 1'b1);
    endtask

    task automatic key(input int kc);
        cycle(1'b0, 0, 0, 0, 1'b1, kc, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; key_valid = 1'b0; out_ready = 1'b1;
        init_l = '0; init_m = '0; init_r = '0; key_code = '0;
        t_l = 0; t_m = 1; t_r = 2;
        type_l = 3'd0; type_m = 3'd1; type_r = 3'd2;
        m_l = 0; m_m = 0; m_r = 0; m_valid = 1'b0; m_code = 0;

        #12;
        check("rst pos_l", pos_l, 0);
        check("rst pos_m", pos_m, 0);
        check("rst pos_r", pos_r, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_code", out_code, 0);
        rst_n = 1'b1;
        #1;
        check("rst key_ready", key_ready, 1);
        @(posedge clk);
        #1;

        // Basic: I/II/III at 0,0,0, key A.
        load_pos(0, 0, 0);
        key(0);
        check("basic pos_r", pos_r, 1);
        check("basic pos_m", pos_m, 0);
        check("basic out_code", out_code, 1);

        // Double-step sequence from (0,3,20).
        load_pos(0, 3, 20);
        key(0);
        check("ds1 pos_r", pos_r, 21);
        key(0);
        check("ds2 pos_m", pos_m, 4);
        key(0);
        check("ds3 pos_r", pos_r, 23);
`ifdef ENIGMA_DOUBLE_STEP_EN
        check("ds3 pos_m", pos_m, 5);
        check("ds3 pos_l", pos_l, 1);
`else
        check("ds3 pos_m", pos_m, 4);
        check("ds3 pos_l", pos_l, 0);
`endif

        // Right rotor type VI: wrap at Z, second notch at M.
        t_l = 0; t_m = 0; t_r = 5;
        load_pos(0, 0, 25);
        key(3);
        check("wrap pos_r", pos_r, 0);
        check("wrap pos_m", pos_m, 1);
        check("wrap out_code", out_code, 3);
        load_pos(0, 1, 12);
        key(0);
        check("notchM pos_m", pos_m, 2);

        // Back-pressure: first key held for 5 cycles, second accepted on release.
        load_pos(0, 0, 0);
        cycle(1'b0, 0, 0, 0, 1'b1, 5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 0, 0, 0, 1'b1, 7, 1'b0);
            check("bp held out_code", out_code, 6);
        end
        cycle(1'b0, 0, 0, 0, 1'b1, 7, 1'b1);
        check("bp second out_code", out_code, 9);

        // Load while output pending.
        load_pos(3, 4, 5);
        check("ld out_valid", out_valid, 0);
        check("ld pos_r", pos_r, 5);

        // Out-of-range key consumed without effect.
        key(27);
        check("bad key pos_r", pos_r, 5);
        check("bad key out_valid", out_valid, 0);

        // Asynchronous reset between edges.
        key(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async pos_l", pos_l, 0);
        check("async pos_m", pos_m, 0);
        check("async pos_r", pos_r, 0);
        check("async out_valid", out_valid, 0);
        check("async out_code", out_code, 0);
        m_l = 0; m_m = 0; m_r = 0; m_valid = 1'b0;
        #1;
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                t_l = $urandom_range(0, 7);
                t_m = $urandom_range(0, 7);
                t_r = $urandom_range(0, 7);
                cycle(1'b1, $urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25),
                      1'($urandom_range(0, 1)), $urandom_range(0, 25), 1'($urandom_range(0, 1)));
            end else begin
                cycle(1'b0, 0, 0, 0, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 28),
                      1'($urandom_range(0, 3) != 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rotor_stepper.md
# rotor_stepper

Rotor position and stepping stage for the Enigma datapath. It sits directly upstream of the rotor wiring lookup. On each accepted key it advances the three rotor positions using the notch rules for the selected rotor types. It then emits the right-rotor entry code, (key + right position) mod 26, through a single-entry valid/ready output buffer.

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset; asynchronous, active-low.
- load  in  1  load start positions; takes priority over key traffic.
- init_l / init_m / init_r  in  5 each  start positions, 0..25.
- type_l / type_m / type_r  in  3 each  rotor type, 0..7 = I..VIII; same encoding as the wiring lookup.
- key_valid  in  1  key_code is presented.
- key_ready  out  1  stage can accept a key.
- key_code  in  5  plaintext letter, 0..25.
- out_valid  out  1  out_code is held.
- out_ready  in  1  downstream accepts.
- out_code  out  5  (key_code + pos_r) mod 26, using the post-step pos_r.
- pos_l / pos_m / pos_r  out  5 each  current rotor positions, registered.

## Operation
- Notch positions (value held before the step):
  - I=16 (Q), II=4 (E), III=21 (V), IV=9 (J), V=25 (Z).
  - VI, VII, VIII = 25 and 12 (Z and M).
- Key accept: key_valid && key_ready && !load.
- Step on accept, all decisions from the pre-step positions:
  - Right rotor always steps.
  - Middle rotor steps if right is at its notch, or if middle is at its own notch (double step).
  - Left rotor steps if middle is at its notch.
- Position arithmetic is mod 26: 25+1 wraps to 0. Implement it as compare-and-clear, not a divider.
- out_code is computed as a 6-bit sum with a conditional subtract of 26.
- key_code >= 26 on accept: key is consumed, no step, no output produced.
- Out-of-range init_* values are loaded unchanged. Behaviour after that is undefined and not verified.
- Output buffer:
  - key_ready = !load && (!out_valid || out_ready). Same-cycle drain and refill is allowed.
  - out_code is held stable while out_valid && !out_ready.
- Load: pos_* <= init_*, out_valid <= 0. Any pending out_code is discarded. load held high keeps reloading.
- type_* are sampled every cycle. They must be held stable while keys are in flight, and are not registered.

## Timing
- Reset values:
  - pos_l/m/r = 0, out_code = 0, out_valid = 0.
  - key_ready = 1 once rst_n is high and load is low.
- Latency: key accepted at edge N gives out_valid=1 and updated pos_* visible after edge N, i.e. in cycle N+1.
- Throughput: one key per cycle while out_ready is held high.
- Reset asserted mid-operation: all state clears immediately without waiting for clk. A pending output is lost.
- load and key_valid in the same cycle: load wins; the key is not accepted (key_ready=0).

## Configuration
- ENIGMA_DOUBLE_STEP_EN defined: middle-rotor double step as described in Operation. This is historical Enigma behaviour.
- ENIGMA_DOUBLE_STEP_EN undefined: pure odometer stepping.
  - Middle rotor steps only when right is at its notch.
  - Left rotor steps only when middle and right are both at their notches.
  - Types VI–VIII keep both notches.

## Test plan
- Reset, then load types I/II/III (0,1,2) at 0,0,0; key 0 -> out_valid next cycle, pos=(0,0,1), out_code=1.
- Double step, macro defined: types I/II/III loaded at (0,3,20); three keys -> pos (0,3,21), then (0,4,22), then (1,5,23).
- Same run with macro undefined -> third key gives pos (0,4,23); left stays 0.
- Wrap: right type VI at 25, middle 0, key 3 -> pos_r=0, middle steps to 1, out_code=3. Then right at 12 -> the next key also steps the middle.
- Back-pressure: out_ready=0, two keys offered.
  - First key is accepted; key_ready then drops and out_code is held for 5 cycles.
  - Raising out_ready accepts the second key in the same cycle.
- Disruption cases:
  - load asserted while out_valid=1 -> out_valid=0 next cycle and pos=init.
  - rst_n pulsed low between clock edges -> outputs reach reset values before the next edge.
  - key_code=27 -> no step, no out_valid.
